// File: rtl/bu_mem_port.sv
// bu_mem_port: arbitrates IF fetches and MEM-stage data accesses onto one shared external memory bus.
// Define BU_MEM_PORT_RR_EN for round-robin arbitration; the default build uses fixed MEM-over-IF priority.
module bu_mem_port #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ack,
   output logic [ADDR_W-1:0] Memory_addressbus,
   inout  wire  [DATA_W-1:0] Memory_databus,
   output logic              Memory_writemode,
   output logic              busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;
   localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic              grant_mem_q, grant_mem_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              req_any;
   logic              pick_mem;
   logic              capture;
   logic              bus_drive;

   assign req_any = if_req | mem_req;

`ifdef BU_MEM_PORT_RR_EN
   // last_mem_q: 0 = IF was granted last, 1 = MEM was granted last
   logic last_mem_q, last_mem_d;

   assign pick_mem = mem_req & (~if_req | ~last_mem_q);

   always_comb begin
      last_mem_d = last_mem_q;
      if (state_q == ST_IDLE && req_any) begin
         last_mem_d = pick_mem;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_mem_q <= 1'b0;
      end else begin
         last_mem_q <= last_mem_d;
      end
   end
`else
   assign pick_mem = mem_req;
`endif

   // Read data is sampled in the final wait cycle, while the memory still sees the address.
   assign capture = (state_q == ST_ACCESS) && (cnt_q == 4'd1) && !we_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      we_d        = we_q;
      grant_mem_d = grant_mem_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               grant_mem_d = pick_mem;
               addr_d      = pick_mem ? mem_addr : if_addr;
               we_d        = pick_mem & mem_we;
               wdata_d     = mem_wdata;
               cnt_d       = WAIT_LD;
               state_d     = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ST_DONE;
            end
            if (capture) begin
               if (grant_mem_q) begin
                  mem_rdata_d = Memory_databus;
               end else begin
                  if_rdata_d = Memory_databus;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         grant_mem_q <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         grant_mem_q <= grant_mem_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   // Write data only reaches the bus while we_q is set in ACCESS, so it needs no reset.
   always_ff @(posedge clk) begin
      wdata_q <= wdata_d;
   end

   assign bus_drive         = (state_q == ST_ACCESS) && we_q;
   assign Memory_databus    = bus_drive ? wdata_q : {DATA_W{1'bz}};
   assign Memory_addressbus = addr_q;
   assign Memory_writemode  = bus_drive;
   assign busy              = (state_q != ST_IDLE);
   assign if_ack            = (state_q == ST_DONE) && !grant_mem_q;
   assign mem_ack           = (state_q == ST_DONE) && grant_mem_q;
   assign if_rdata          = if_rdata_q;
   assign mem_rdata         = mem_rdata_q;

endmodule

// File: tb/tb_bu_mem_port.sv
// Scoreboard bench for bu_mem_port: one instance with WAIT_CYCLES=1 and one with WAIT_CYCLES=3,
// each attached to a small memory model on its bidirectional data bus.
module tb_bu_mem_port;

   localparam int AW = 12;
   localparam int DW = 16;

   typedef struct packed {
      logic          is_mem;
      logic          is_wr;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          a_if_req, a_if_ack, a_mem_req, a_mem_we, a_mem_ack, a_wm, a_busy;
   logic [AW-1:0] a_if_addr, a_mem_addr, a_addrbus;
   logic [DW-1:0] a_if_rdata, a_mem_wdata, a_mem_rdata;
   wire  [DW-1:0] a_bus;

   logic          b_if_req, b_if_ack, b_mem_req, b_mem_we, b_mem_ack, b_wm, b_busy;
   logic [AW-1:0] b_if_addr, b_mem_addr, b_addrbus;
   logic [DW-1:0] b_if_rdata, b_mem_wdata, b_mem_rdata;
   wire  [DW-1:0] b_bus;

   bu_mem_port #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u_dut_w1 (
      .clk(clk), .rst(rst),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
      .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack),
      .Memory_addressbus(a_addrbus), .Memory_databus(a_bus), .Memory_writemode(a_wm), .busy(a_busy)
   );

   bu_mem_port #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3)) u_dut_w3 (
      .clk(clk), .rst(rst),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
      .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
      .Memory_addressbus(b_addrbus), .Memory_databus(b_bus), .Memory_writemode(b_wm), .busy(b_busy)
   );

   function automatic logic [DW-1:0] pat_a(input logic [AW-1:0] ad);
      return (ad == 12'h012) ? 16'hBEEF : {4'hD, ad};
   endfunction

   function automatic logic [DW-1:0] pat_b(input logic [AW-1:0] ad);
      return {4'h7, ~ad};
   endfunction

   // Memory models: drive read data during an access, a 0xA5A5 idle pattern otherwise,
   // and release the bus whenever the port asserts write mode.
   bit            a_wr_seen = 1'b0;
   int            a_wr_cnt  = 0;
   logic [AW-1:0] a_wr_addr;
   logic [DW-1:0] a_wr_data;
   logic [DW-1:0] a_rd, a_drv;

   always_comb begin
      a_rd  = (a_wr_seen && a_addrbus == a_wr_addr) ? a_wr_data : pat_a(a_addrbus);
      a_drv = (a_busy && !a_if_ack && !a_mem_ack) ? a_rd : 16'hA5A5;
   end
   assign a_bus = a_wm ? {DW{1'bz}} : a_drv;

   always @(posedge clk) begin
      if (a_wm) begin
         a_wr_seen <= 1'b1;
         a_wr_addr <= a_addrbus;
         a_wr_data <= a_bus;
         a_wr_cnt  <= a_wr_cnt + 1;
      end
   end

   assign b_bus = b_wm ? {DW{1'bz}} :
                  ((b_busy && !b_if_ack && !b_mem_ack) ? pat_b(b_addrbus) : 16'hA5A5);

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h, required 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && (a_if_ack || a_mem_ack)) begin
         chk_val("a_single_ack", 32'(a_if_ack & a_mem_ack), 32'd0);
         if (qa.size() == 0) begin
            chk_val("a_unexpected_ack", 32'(qa.size()), 32'd1);
         end else begin
            ea = qa.pop_front();
            chk_val("a_ack_port", 32'(a_mem_ack), 32'(ea.is_mem));
            if (!ea.is_wr) chk_val("a_ack_data", 32'(ea.is_mem ? a_mem_rdata : a_if_rdata), 32'(ea.data));
         end
      end
      if (!rst && (b_if_ack || b_mem_ack)) begin
         chk_val("b_single_ack", 32'(b_if_ack & b_mem_ack), 32'd0);
         if (qb.size() == 0) begin
            chk_val("b_unexpected_ack", 32'(qb.size()), 32'd1);
         end else begin
            eb = qb.pop_front();
            chk_val("b_ack_port", 32'(b_mem_ack), 32'(eb.is_mem));
            if (!eb.is_wr) chk_val("b_ack_data", 32'(eb.is_mem ? b_mem_rdata : b_if_rdata), 32'(eb.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

   initial begin
      int cyc;
      rst = 1'b1;
      a_if_req = 1'b0; a_if_addr = '0; a_mem_req = 1'b0; a_mem_we = 1'b0; a_mem_addr = '0; a_mem_wdata = '0;
      b_if_req = 1'b0; b_if_addr = '0; b_mem_req = 1'b0; b_mem_we = 1'b0; b_mem_addr = '0; b_mem_wdata = '0;
      tick(2);
      chk_val("rst_busy", 32'(a_busy), 32'd0);
      chk_val("rst_writemode", 32'(a_wm), 32'd0);
      chk_val("rst_addrbus", 32'(a_addrbus), 32'd0);
      chk_val("rst_acks", 32'({a_if_ack, a_mem_ack}), 32'd0);
      chk_val("rst_rdata", 32'({a_if_rdata, a_mem_rdata}), 32'd0);
      chk_val("rst_bus_released", 32'(a_bus), 32'hA5A5);
      chk_val("rst_busy_w3", 32'(b_busy), 32'd0);
      rst = 1'b0;
      tick(1);

      // Single fetch, WAIT=1
      a_if_addr = 12'h012; a_if_req = 1'b1;
      qa.push_back('{1'b0, 1'b0, 16'hBEEF});
      tick(1);
      chk_val("fetch_busy_n1", 32'(a_busy), 32'd1);
      chk_val("fetch_addrbus_n1", 32'(a_addrbus), 32'h012);
      chk_val("fetch_writemode_n1", 32'(a_wm), 32'd0);
      chk_val("fetch_ack_n1", 32'(a_if_ack), 32'd0);
      tick(1);
      chk_val("fetch_ack_n2", 32'(a_if_ack), 32'd1);
      chk_val("fetch_rdata_n2", 32'(a_if_rdata), 32'hBEEF);
      chk_val("fetch_busy_n2", 32'(a_busy), 32'd1);
      tick(1);
      chk_val("fetch_no_regrant", 32'(a_busy), 32'd0);
      chk_val("fetch_ack_n3", 32'(a_if_ack), 32'd0);
      a_if_req = 1'b0;
      tick(1);

      // Write 0x1234 to 0xFFF
      a_mem_we = 1'b1; a_mem_addr = 12'hFFF; a_mem_wdata = 16'h1234; a_mem_req = 1'b1;
      qa.push_back('{1'b1, 1'b1, 16'h0000});
      tick(1);
      chk_val("wr_writemode_on", 32'(a_wm), 32'd1);
      chk_val("wr_bus_data", 32'(a_bus), 32'h1234);
      chk_val("wr_addrbus", 32'(a_addrbus), 32'hFFF);
      tick(1);
      chk_val("wr_writemode_off", 32'(a_wm), 32'd0);
      chk_val("wr_bus_released_done", 32'(a_bus), 32'hA5A5);
      chk_val("wr_ack", 32'(a_mem_ack), 32'd1);
      chk_val("wr_addr_held", 32'(a_addrbus), 32'hFFF);
      chk_val("wr_rdata_unchanged", 32'(a_mem_rdata), 32'd0);
      a_mem_req = 1'b0; a_mem_we = 1'b0;
      tick(1);
      chk_val("wr_ack_single", 32'(a_mem_ack), 32'd0);
      chk_val("wr_mem_count", 32'(a_wr_cnt), 32'd1);
      chk_val("wr_mem_addr", 32'(a_wr_addr), 32'hFFF);
      chk_val("wr_mem_data", 32'(a_wr_data), 32'h1234);

      // Request dropped and fields changed one cycle after grant
      a_mem_addr = 12'h040; a_mem_req = 1'b1;
      qa.push_back('{1'b1, 1'b0, pat_a(12'h040)});
      tick(1);
      a_mem_req = 1'b0; a_mem_addr = 12'h041;
      tick(1);
      chk_val("drop_ack", 32'(a_mem_ack), 32'd1);
      chk_val("drop_rdata", 32'(a_mem_rdata), 32'(pat_a(12'h040)));
      tick(1);
      chk_val("drop_ack_once", 32'(a_mem_ack), 32'd0);
      tick(2);
      chk_val("drop_idle", 32'(a_busy), 32'd0);

      // Reset in the middle of a write access
      a_mem_we = 1'b1; a_mem_addr = 12'h055; a_mem_wdata = 16'h7777; a_mem_req = 1'b1;
      tick(1);
      chk_val("abort_writemode_pre", 32'(a_wm), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk_val("abort_writemode", 32'(a_wm), 32'd0);
      chk_val("abort_busy", 32'(a_busy), 32'd0);
      chk_val("abort_bus_released", 32'(a_bus), 32'hA5A5);
      chk_val("abort_addrbus", 32'(a_addrbus), 32'd0);
      chk_val("abort_acks", 32'({a_if_ack, a_mem_ack}), 32'd0);
      chk_val("abort_rdata_cleared", 32'(a_mem_rdata), 32'd0);
      a_mem_req = 1'b0; a_mem_we = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(3);
      chk_val("abort_stays_idle", 32'(a_busy), 32'd0);
      chk_val("abort_no_mem_write", 32'(a_wr_cnt), 32'd1);

      // Contention with MEM re-requesting immediately after its first ack
      a_if_addr = 12'h020; a_mem_addr = 12'h030; a_mem_we = 1'b0;
      a_if_req = 1'b1; a_mem_req = 1'b1;
      qa.push_back('{1'b1, 1'b0, pat_a(12'h030)});
`ifdef BU_MEM_PORT_RR_EN
      qa.push_back('{1'b0, 1'b0, pat_a(12'h020)});
      qa.push_back('{1'b1, 1'b0, pat_a(12'h031)});
`else
      qa.push_back('{1'b1, 1'b0, pat_a(12'h031)});
      qa.push_back('{1'b0, 1'b0, pat_a(12'h020)});
`endif
      tick(2);
      chk_val("cont1_mem_ack", 32'(a_mem_ack), 32'd1);
      chk_val("cont1_if_ack", 32'(a_if_ack), 32'd0);
      a_mem_addr = 12'h031;
      tick(1);
      chk_val("cont_turnaround_idle", 32'(a_busy), 32'd0);
      tick(2);
`ifdef BU_MEM_PORT_RR_EN
      chk_val("cont2_if_ack", 32'(a_if_ack), 32'd1);
      a_if_req = 1'b0;
      tick(3);
      chk_val("cont3_mem_ack", 32'(a_mem_ack), 32'd1);
      a_mem_req = 1'b0;
`else
      chk_val("cont2_mem_ack", 32'(a_mem_ack), 32'd1);
      a_mem_req = 1'b0;
      tick(3);
      chk_val("cont3_if_ack", 32'(a_if_ack), 32'd1);
      a_if_req = 1'b0;
`endif
      tick(2);
      chk_val("cont_idle", 32'(a_busy), 32'd0);

      // Back-to-back fetches with WAIT_CYCLES=3
      for (int k = 0; k < 8; k++) qb.push_back('{1'b0, 1'b0, pat_b(AW'(k))});
      b_if_addr = '0; b_if_req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cyc = 0;
         do begin
            tick(1);
            cyc++;
         end while (!b_if_ack && cyc < 20);
         chk_val("stream_ack_gap", 32'(cyc), (k == 0) ? 32'd4 : 32'd5);
         if (k < 7) b_if_addr = AW'(k + 1);
         else b_if_req = 1'b0;
      end
      tick(3);
      chk_val("stream_idle", 32'(b_busy), 32'd0);
      chk_val("a_sb_drained", 32'(qa.size()), 32'd0);
      chk_val("b_sb_drained", 32'(qb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
